// File: rtl/multi_cycle_counter_pkg.sv
// Shared types and helpers for the multi-channel start/stop cycle counter.
// Channel state encoding, result layout and the round-robin search used by the arbiter.
package multi_cycle_counter_pkg;

   localparam int MAX_CH    = 16;
   localparam int MAX_CNT_W = 64;

   typedef enum logic {
      IDLE     = 1'b0,
      COUNTING = 1'b1
   } ch_state_t;

   // Widest result layout; narrower builds use the low CNT_W bits of count.
   typedef struct packed {
      logic [MAX_CNT_W-1:0] count;
      logic                 sat;
   } result_t;

   function automatic result_t make_result(input logic [MAX_CNT_W-1:0] count,
                                           input logic sat, input int width);
      result_t r;
      r.count = (width >= MAX_CNT_W) ? count : (count & ((64'd1 << width) - 64'd1));
      r.sat   = sat;
      return r;
   endfunction

   // Returns {found, index} of the first set request at or after ptr, wrapping at n.
   function automatic logic [4:0] rr_pick(input logic [MAX_CH-1:0] req,
                                          input logic [3:0] ptr, input int n);
      logic [4:0] r;
      int         j;
      r = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         j = int'(ptr) + i;
         if (j >= n) j = j - n;
         if (i < n && !r[4] && req[j[3:0]]) r = {1'b1, j[3:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/multi_cycle_counter_ch.sv
// One measurement channel: edge detect, FSM, saturating counter and one-deep result slot.
// Defining CYCLE_CNT_SYNC_EN adds a 2-flop synchronizer on start and stop.
module multi_cycle_counter_ch
   import multi_cycle_counter_pkg::*;
#(
   parameter int CNT_W            = 32,
   parameter int RESTART_ON_START = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic             pop,
   output logic             busy,
   output logic             slot_full,
   output logic [CNT_W-1:0] slot_count,
   output logic             slot_sat,
   output logic             drop
);

   logic start_s, stop_s;

`ifdef CYCLE_CNT_SYNC_EN
   logic [1:0] sync_start_q, sync_start_d, sync_stop_q, sync_stop_d;
   assign sync_start_d = clear ? 2'b00 : {sync_start_q[0], start};
   assign sync_stop_d  = clear ? 2'b00 : {sync_stop_q[0], stop};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_start_q <= 2'b00;
         sync_stop_q  <= 2'b00;
      end else begin
         sync_start_q <= sync_start_d;
         sync_stop_q  <= sync_stop_d;
      end
   end
   assign start_s = sync_start_q[1];
   assign stop_s  = sync_stop_q[1];
`else
   assign start_s = start;
   assign stop_s  = stop;
`endif

   ch_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, slot_count_q, slot_count_d;
   logic             sat_q, sat_d, inc_sat, slot_full_q, slot_full_d, slot_sat_q, slot_sat_d;
   logic             start_prev_q, start_prev_d, stop_prev_q, stop_prev_d;
   logic             start_edge, stop_edge, capture;

   assign start_edge = start_s & ~start_prev_q;
   assign stop_edge  = stop_s & ~stop_prev_q;
   // Captured value is the count including the stop cycle itself.
   assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign inc_sat    = (cnt_inc == '1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sat_d        = sat_q;
      slot_full_d  = slot_full_q;
      slot_count_d = slot_count_q;
      slot_sat_d   = slot_sat_q;
      start_prev_d = start_s;
      stop_prev_d  = stop_s;
      capture      = 1'b0;
      drop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d = COUNTING;
               cnt_d   = '0;
               sat_d   = 1'b0;
            end
         end
         COUNTING: begin
            if (stop_edge) begin
               state_d = IDLE;
               capture = 1'b1;
            end else if (start_edge && RESTART_ON_START != 0) begin
               cnt_d = '0;
               sat_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
               sat_d = sat_q | inc_sat;
            end
         end
         default: state_d = IDLE;
      endcase
      if (capture) begin
         if (!slot_full_q || pop) begin
            slot_full_d  = 1'b1;
            slot_count_d = cnt_inc;
            slot_sat_d   = sat_q | inc_sat;
         end else begin
            drop = 1'b1;
         end
      end else if (pop) begin
         slot_full_d = 1'b0;
      end
      if (clear) begin
         state_d      = IDLE;
         cnt_d        = '0;
         sat_d        = 1'b0;
         slot_full_d  = 1'b0;
         slot_count_d = '0;
         slot_sat_d   = 1'b0;
         start_prev_d = 1'b0;
         stop_prev_d  = 1'b0;
         drop         = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sat_q        <= 1'b0;
         slot_full_q  <= 1'b0;
         slot_count_q <= '0;
         slot_sat_q   <= 1'b0;
         start_prev_q <= 1'b0;
         stop_prev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sat_q        <= sat_d;
         slot_full_q  <= slot_full_d;
         slot_count_q <= slot_count_d;
         slot_sat_q   <= slot_sat_d;
         start_prev_q <= start_prev_d;
         stop_prev_q  <= stop_prev_d;
      end
   end

   assign busy       = (state_q == COUNTING);
   assign slot_full  = slot_full_q;
   assign slot_count = slot_count_q;
   assign slot_sat   = slot_sat_q;

endmodule

// File: rtl/multi_cycle_counter.sv
// Multi-channel start/stop cycle counter with a shared round-robin valid/ready result port.
// Optional CYCLE_CNT_SYNC_EN (in the channel) synchronizes start/stop before edge detection.
module multi_cycle_counter
   import multi_cycle_counter_pkg::*;
#(
   parameter int NUM_CH           = 4,
   parameter int CNT_W            = 32,
   parameter int RESTART_ON_START = 0,
   localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] start,
   input  logic [NUM_CH-1:0] stop,
   input  logic              clear,
   output logic [NUM_CH-1:0] busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CH_W-1:0]   res_ch,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_sat,
   output logic [NUM_CH-1:0] ovf
);

   logic [NUM_CH-1:0] slot_full, slot_sat, drop, pop;
   logic [CNT_W-1:0]  slot_count [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      multi_cycle_counter_ch #(
         .CNT_W            (CNT_W),
         .RESTART_ON_START (RESTART_ON_START)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .clear      (clear),
         .start      (start[g]),
         .stop       (stop[g]),
         .pop        (pop[g]),
         .busy       (busy[g]),
         .slot_full  (slot_full[g]),
         .slot_count (slot_count[g]),
         .slot_sat   (slot_sat[g]),
         .drop       (drop[g])
      );
   end

   logic              res_valid_q, res_valid_d, res_sat_q, res_sat_d;
   logic [CH_W-1:0]   res_ch_q, res_ch_d, ptr_q, ptr_d;
   logic [CNT_W-1:0]  res_count_q, res_count_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [MAX_CH-1:0] req;
   logic [4:0]        pick;
   logic [3:0]        grant_idx;
   logic              grant_vld, load;

   // Valid/ready: a result transfers on a cycle where res_valid and res_ready are both high;
   // the output register only reloads when empty or on such a transfer.
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_CH; i++) req[i] = slot_full[i];
      pick      = rr_pick(req, 4'(ptr_q), NUM_CH);
      grant_vld = pick[4];
      grant_idx = pick[3:0];
      load      = !res_valid_q || res_ready;
      for (int i = 0; i < NUM_CH; i++) pop[i] = load && grant_vld && (grant_idx == 4'(i));

      res_valid_d = res_valid_q;
      res_ch_d    = res_ch_q;
      res_count_d = res_count_q;
      res_sat_d   = res_sat_q;
      ptr_d       = ptr_q;
      ovf_d       = ovf_q | drop;
      if (load) begin
         res_valid_d = grant_vld;
         if (grant_vld) begin
            res_ch_d    = CH_W'(grant_idx);
            res_count_d = slot_count[grant_idx[CH_W-1:0]];
            res_sat_d   = slot_sat[grant_idx[CH_W-1:0]];
            ptr_d       = (grant_idx == 4'(NUM_CH - 1)) ? '0 : CH_W'(grant_idx + 4'd1);
         end
      end
      if (clear) begin
         res_valid_d = 1'b0;
         res_ch_d    = '0;
         res_count_d = '0;
         res_sat_d   = 1'b0;
         ptr_d       = '0;
         ovf_d       = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid_q <= 1'b0;
         res_ch_q    <= '0;
         res_count_q <= '0;
         res_sat_q   <= 1'b0;
         ptr_q       <= '0;
         ovf_q       <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_ch_q    <= res_ch_d;
         res_count_q <= res_count_d;
         res_sat_q   <= res_sat_d;
         ptr_q       <= ptr_d;
         ovf_q       <= ovf_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_ch    = res_ch_q;
   assign res_count = res_count_q;
   assign res_sat   = res_sat_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_multi_cycle_counter.sv
// Directed bench for multi_cycle_counter: one instance ignores restarts, a second restarts.
// Both share stimulus; CNT_W=8 so saturation is reachable in a few hundred cycles.
module tb_multi_cycle_counter;

   logic       clk, reset, clear, res_ready;
   logic [3:0] start, stop;
   logic [3:0] busy, ovf, busy_r, ovf_r;
   logic       res_valid, res_sat, res_valid_r, res_sat_r;
   logic [1:0] res_ch, res_ch_r;
   logic [7:0] res_count, res_count_r;
   int         checks = 0;
   int         errors = 0;

   multi_cycle_counter #(.NUM_CH(4), .CNT_W(8), .RESTART_ON_START(0)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
      .res_count(res_count), .res_sat(res_sat), .ovf(ovf)
   );

   multi_cycle_counter #(.NUM_CH(4), .CNT_W(8), .RESTART_ON_START(1)) dut_r (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .busy(busy_r), .res_valid(res_valid_r), .res_ready(res_ready), .res_ch(res_ch_r),
      .res_count(res_count_r), .res_sat(res_sat_r), .ovf(ovf_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic apply_reset();
      start = '0; stop = '0; clear = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic idle(input int n);
      start = '0; stop = '0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({res_valid, res_ch, res_count, res_sat, busy, ovf} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected 0", {res_valid, res_ch, res_count, res_sat, busy, ovf});
      end
   endtask

   // ch0: start edge at c0, stop edge at c15 -> count 15, res_valid at c17, busy c1..c15.
   task automatic test_single();
      for (int c = 0; c < 20; c++) begin
         start = {3'b000, 1'b1};
         stop  = {3'b000, c == 15};
         @(negedge clk);
         checks++;
         if (busy[0] !== (c >= 1 && c <= 15)) begin
            errors++; $display("FAIL single_busy c=%0d got %b expected %b", c, busy[0], (c >= 1 && c <= 15));
         end
         checks++;
         if (res_valid !== (c == 17)) begin
            errors++; $display("FAIL single_valid c=%0d got %b expected %b", c, res_valid, (c == 17));
         end
         if (c == 17) begin
            checks++;
            if ({res_ch, res_count, res_sat} !== {2'd0, 8'd15, 1'b0}) begin
               errors++; $display("FAIL single_result got ch=%0d cnt=%0d sat=%b expected ch=0 cnt=15 sat=0", res_ch, res_count, res_sat);
            end
         end
         @(posedge clk); #1;
      end
      idle(2);
   endtask

   task automatic test_saturate();
      for (int c = 0; c < 305; c++) begin
         start = {2'b00, c < 3, 1'b0};
         stop  = {2'b00, c == 300, 1'b0};
         @(negedge clk);
         if (c == 301 || c == 303) begin
            checks++;
            if (res_valid !== 1'b0) begin
               errors++; $display("FAIL sat_valid_low c=%0d got %b expected 0", c, res_valid);
            end
         end
         if (c == 302) begin
            checks++;
            if ({res_valid, res_ch, res_count, res_sat} !== {1'b1, 2'd1, 8'd255, 1'b1}) begin
               errors++; $display("FAIL sat_result got v=%b ch=%0d cnt=%0d sat=%b expected v=1 ch=1 cnt=255 sat=1", res_valid, res_ch, res_count, res_sat);
            end
         end
         @(posedge clk); #1;
      end
      idle(2);
   endtask

   // Channel i starts at c=i, all stop at c8 -> count 8-i; results at c10..c13 in order first..first+3.
   task automatic run_batch(input int first, input string tag);
      int ch;
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < 4; i++) start[i] = (c >= i);
         stop = (c == 8) ? 4'hF : 4'h0;
         @(negedge clk);
         if (c >= 9) begin
            checks++;
            if (res_valid !== (c >= 10 && c <= 13)) begin
               errors++; $display("FAIL %s_valid c=%0d got %b expected %b", tag, c, res_valid, (c >= 10 && c <= 13));
            end
         end
         if (c >= 10 && c <= 13) begin
            ch = (first + c - 10) % 4;
            checks++;
            if ({res_ch, res_count, res_sat} !== {2'(ch), 8'(8 - ch), 1'b0}) begin
               errors++; $display("FAIL %s_order c=%0d got ch=%0d cnt=%0d expected ch=%0d cnt=%0d", tag, c, res_ch, res_count, ch, 8 - ch);
            end
         end
         @(posedge clk); #1;
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      res_ready = 1'b1;
      run_batch(0, "rr1");
      for (int c = 0; c < 7; c++) begin
         start = {2'b00, 1'b1, 1'b0};
         stop  = {2'b00, c == 3, 1'b0};
         @(negedge clk);
         if (c == 5) begin
            checks++;
            if ({res_valid, res_ch, res_count} !== {1'b1, 2'd1, 8'd3}) begin
               errors++; $display("FAIL rr_single got v=%b ch=%0d cnt=%0d expected v=1 ch=1 cnt=3", res_valid, res_ch, res_count);
            end
         end
         @(posedge clk); #1;
      end
      idle(2);
      run_batch(2, "rr2");
   endtask

   // Output register holds ch0 while ch2 fills its slot and then loses a second result.
   task automatic test_overflow();
      apply_reset();
      for (int c = 0; c < 17; c++) begin
         res_ready = (c >= 12);
         start[0] = (c <= 1);
         start[1] = 1'b0;
         start[2] = (c == 1 || c == 2 || c == 6 || c == 7);
         start[3] = 1'b0;
         stop = {1'b0, (c == 4 || c == 9), 1'b0, c == 2};
         @(negedge clk);
         checks++;
         if (ovf !== ((c >= 10) ? 4'b0100 : 4'b0000)) begin
            errors++; $display("FAIL ovf_flag c=%0d got %b expected %b", c, ovf, (c >= 10) ? 4'b0100 : 4'b0000);
         end
         if (c >= 4 && c <= 12) begin
            checks++;
            if ({res_valid, res_ch, res_count} !== {1'b1, 2'd0, 8'd2}) begin
               errors++; $display("FAIL ovf_hold c=%0d got v=%b ch=%0d cnt=%0d expected v=1 ch=0 cnt=2", c, res_valid, res_ch, res_count);
            end
         end
         if (c == 13) begin
            checks++;
            if ({res_valid, res_ch, res_count} !== {1'b1, 2'd2, 8'd3}) begin
               errors++; $display("FAIL ovf_first got v=%b ch=%0d cnt=%0d expected v=1 ch=2 cnt=3", res_valid, res_ch, res_count);
            end
         end
         if (c >= 14) begin
            checks++;
            if (res_valid !== 1'b0) begin
               errors++; $display("FAIL ovf_no_second c=%0d got %b expected 0", c, res_valid);
            end
         end
         @(posedge clk); #1;
      end
      idle(2);
   endtask

   task automatic test_restart();
      apply_reset();
      res_ready = 1'b1;
      for (int c = 0; c < 31; c++) begin
         start = {3'b000, (c == 0 || c == 5 || c == 20 || c == 24)};
         stop  = {3'b000, (c == 12 || c == 24 || c == 28)};
         @(negedge clk);
         checks++;
         if ({res_valid, res_valid_r} !== {2{(c == 14 || c == 26)}}) begin
            errors++; $display("FAIL restart_valid c=%0d got %b%b expected %b", c, res_valid, res_valid_r, (c == 14 || c == 26));
         end
         if (c == 14) begin
            checks++;
            if (res_count !== 8'd12) begin
               errors++; $display("FAIL restart_off_count got %0d expected 12", res_count);
            end
            checks++;
            if (res_count_r !== 8'd7) begin
               errors++; $display("FAIL restart_on_count got %0d expected 7", res_count_r);
            end
         end
         if (c == 25) begin
            checks++;
            if ({busy[0], busy_r[0]} !== 2'b00) begin
               errors++; $display("FAIL startstop_busy got %b%b expected 00", busy[0], busy_r[0]);
            end
         end
         if (c == 26) begin
            checks++;
            if ({res_count, res_count_r} !== {8'd4, 8'd4}) begin
               errors++; $display("FAIL startstop_count got %0d/%0d expected 4/4", res_count, res_count_r);
            end
         end
         @(posedge clk); #1;
      end
      idle(2);
   endtask

   task automatic test_clear();
      apply_reset();
      res_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         start = {1'b0, c <= 1, 1'b0, c <= 1};
         stop  = {1'b0, c == 6, 1'b0, c == 1};
         clear = (c == 3);
         @(negedge clk);
         if (c == 3) begin
            checks++;
            if ({res_valid, res_count, busy[2]} !== {1'b1, 8'd1, 1'b1}) begin
               errors++; $display("FAIL clear_before got v=%b cnt=%0d busy2=%b expected v=1 cnt=1 busy2=1", res_valid, res_count, busy[2]);
            end
         end
         if (c >= 4) begin
            checks++;
            if ({res_valid, res_count, busy} !== 13'd0) begin
               errors++; $display("FAIL clear_after c=%0d got v=%b cnt=%0d busy=%b expected all 0", c, res_valid, res_count, busy);
            end
         end
         @(posedge clk); #1;
      end
      clear = 1'b0;
      idle(2);
   endtask

   task automatic test_async_reset();
      apply_reset();
      res_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         start = {2'b00, c >= 4, c <= 1};
         stop  = {3'b000, c == 3};
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if ({res_valid, res_count, busy[1]} !== {1'b1, 8'd3, 1'b1}) begin
         errors++; $display("FAIL areset_before got v=%b cnt=%0d busy1=%b expected v=1 cnt=3 busy1=1", res_valid, res_count, busy[1]);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({res_valid, res_ch, res_count, res_sat, busy, ovf} !== 17'd0) begin
         errors++; $display("FAIL areset_async got %h expected 0", {res_valid, res_ch, res_count, res_sat, busy, ovf});
      end
      start = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      res_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         stop = (c == 1) ? 4'b0011 : 4'b0000;
         @(negedge clk);
         checks++;
         if ({res_valid, busy} !== 5'd0) begin
            errors++; $display("FAIL areset_stop_only c=%0d got v=%b busy=%b expected 0", c, res_valid, busy);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; res_ready = 1'b1;
      start = '0; stop = '0;
      test_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);
      test_single();
      test_saturate();
      test_back_to_back();
      test_overflow();
      test_restart();
      test_clear();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_cycle_counter.md
Name: multi_cycle_counter

Overview:
- Parametrised, multi-channel successor to the single-channel start/stop cycle counter.
- Each of NUM_CH channels measures elapsed clock cycles between a rising edge on its start input and a rising edge on its stop input.
- Completed measurements queue in a one-deep slot per channel and drain through one shared valid/ready result port under round-robin arbitration.
- Sits beside accelerator pipelines (e.g. SHA-2 cores) for latency profiling; results are read by the host/CSR layer.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, counter and result width in bits (8..64).
- RESTART_ON_START, 0, 1 = a start edge while COUNTING clears the counter and restarts; 0 = ignore it.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  NUM_CH  per-channel start level/pulse; rising edge is significant.
- stop  in  NUM_CH  per-channel stop level/pulse; rising edge is significant.
- clear  in  1  synchronous soft clear of all state.
- busy  out  NUM_CH  channel is in COUNTING.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_ch  out  $clog2(NUM_CH) (min 1)  channel index of the result.
- res_count  out  CNT_W  measured cycle count.
- res_sat  out  1  count saturated at all-ones.
- ovf  out  NUM_CH  sticky: a result was dropped because the slot was full.

Behaviour:
- Reset is asynchronous, active-high, and applies to everything. All outputs go to 0, all channels go to IDLE, all slots empty, arbiter pointer = 0.
- clear has the same effect as reset, but synchronously on the next edge. clear has priority over all other events.

Edge detect:
- Per input: in_q <= in; edge = in && !in_q.
- A level held high produces exactly one edge.

Channel FSM, states IDLE and COUNTING:
- IDLE, start edge: go to COUNTING, cnt <= 0.
- COUNTING: cnt <= cnt+1 each cycle, saturating at 2^CNT_W-1; set sat flag when the all-ones value is reached.
- COUNTING, stop edge: go to IDLE and capture {cnt, sat} into the slot. The result equals the number of cycles between the cycle the start edge is detected and the cycle the stop edge is detected.
- Start and stop edges in the same cycle:
  - In IDLE, only the start edge is acted on.
  - In COUNTING, stop is taken (capture), then the channel returns to IDLE. The start edge is ignored, even with RESTART_ON_START=1.
- Stop edge in IDLE: ignored.
- Start edge while COUNTING: per RESTART_ON_START.

Pending slot (one-deep per channel):
- Capture into an empty slot: slot becomes full.
- Capture while full:
  - If the slot is being popped to the output this cycle, load the new result.
  - Otherwise drop the new result and set ovf[ch]. ovf clears only on reset/clear.

Output register:
- Loads when empty or when res_valid && res_ready.
- Source is the first full slot at or after the rr pointer; the pointer then advances to granted+1, modulo NUM_CH.
- res_valid stays high and res_ch/res_count/res_sat stay stable until accepted.
- Latency, stop edge detected at cycle T:
  - slot full at T+1;
  - res_valid at T+2 if the output register is free;
  - back-to-back results sustain one result per cycle with res_ready held high.

Optional Feature:
- CYCLE_CNT_SYNC_EN defined: start and stop each pass through a 2-flop synchronizer before edge detect.
  - Adds 2 cycles to edge detection.
  - Measured counts are unchanged.
  - Latency from the stop input rising to res_valid becomes 4 cycles.
- Not defined: inputs are treated as synchronous to clk, and edge detect runs directly on the raw inputs.

Decomposition:
- Package multi_cycle_counter_pkg:
  - ch_state_t enum {IDLE, COUNTING};
  - a result struct {count, sat} parametrised by width via a localparam/function;
  - a round-robin helper function.
- Sub-module multi_cycle_counter_ch:
  - one channel;
  - contains edge detect, optional synchronizer, FSM, saturating counter and the pending slot;
  - instantiated NUM_CH times by generate.
- Top level contains the arbiter, output register and ovf flags.

Test Plan:
- ch0: start rises at cycle 10, stop rises at cycle 25, res_ready=1 → one result {ch=0, count=15, sat=0}; res_valid high at cycle 27; busy[0] high for cycles 11..25.
- CNT_W=8, ch1: stop arrives 300 cycles after start → count=255, sat=1.
- All 4 channels stop in the same cycle with res_ready=1 → 4 consecutive results, ch order 0,1,2,3. Repeat the experiment → order continues round-robin from the pointer.
- res_ready=0, ch2 completes two measurements → ovf[2]=1, only the first result is presented. Raise res_ready → first result accepted, no second result.
- RESTART_ON_START=1: start at 0, second start at 5, stop at 12 → count=7. With 0 → count=12.
- Assert reset mid-count and while res_valid=1 → all outputs 0 immediately (asynchronous). After release, a stop edge with no start → no result.
